sreg_readout_ctrl: RTL and testbench
====================================

// Module: sreg_readout_ctrl
// PURPOSE
//  Readout sequencer and deserializer for the pixel shift-register chain. Drives load/shift into
//  the chain on sclk, samples its 2-lane serial output (sreg_out), and rebuilds 42-bit pixel words.
//  Each word is presented on a valid/ready stream to the downstream formatter. Shifting stalls
//  whenever the output is back-pressured, so no bit is ever dropped.
// PARAMETERS
//  NPIX   16  pixels per frame (chain length); >=1
//  PIX_W  42  pixel word width; even; HALF = PIX_W/2 = 21 bits per lane
// PORTS
//  sclk        in   1       chain/system clock, all logic on rising edge
//  rst_n       in   1       synchronous active-low reset, sampled on rising edge of sclk
//  start       in   1       1-cycle request to read one frame; ignored while busy=1
//  sreg_out    in   2       serial lanes from chain, registered there: [0]=low half, [1]=high half
//  load        out  1       parallel-load strobe to chain
//  shift       out  1       shift strobe to chain
//  pix_data    out  PIX_W   reassembled pixel word
//  pix_idx     out  clog2(NPIX)  index of pix_data within frame, 0 = first word out
//  pix_last    out  1       pix_data is word NPIX-1 of the frame
//  pix_valid   out  1       output word valid
//  pix_ready   in   1       downstream accepts; transfer = pix_valid & pix_ready
//  busy        out  1       frame in progress (LOAD/SHIFT/DRAIN)
//  frame_done  out  1       1-cycle pulse when the last word of a frame is accepted
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE; load=shift=0; pix_valid=0; pix_data=0; pix_idx=0;
//   pix_last=0; busy=0; frame_done=0; counters cleared. Reset mid-frame aborts the frame; the
//   partially assembled word and any pending output word are discarded.
//  Chain contract: sreg_out reflects the loaded/shifted contents on the cycle AFTER load or shift
//   is high; it holds while load=shift=0.
//  FSM:
//   IDLE  : start=1 -> LOAD. busy=0.
//   LOAD  : load=1 for exactly one cycle -> SHIFT. bit_cnt=0, word_cnt=0.
//   SHIFT : each cycle with can_take=1, sample sreg_out: asm[bit_cnt]<=sreg_out[0],
//           asm[HALF+bit_cnt]<=sreg_out[1]; shift=1 in the same cycle unless this is the final
//           sample of the frame (word_cnt=NPIX-1, bit_cnt=HALF-1).
//           can_take = (bit_cnt!=HALF-1) | !pix_valid | pix_ready.
//           can_take=0 -> stall: no sample, shift=0, counters hold.
//           Sample at bit_cnt=HALF-1: word {lane1 bits, lane0 bits} goes to the output register
//           next edge with pix_valid=1 and pix_idx=word_cnt; bit_cnt wraps to 0 and word_cnt
//           increments. Final sample -> DRAIN.
//   DRAIN : hold pix_valid until accepted; on accept -> IDLE, frame_done=1 that cycle (registered
//           pulse, visible next cycle), busy drops with IDLE.
//  Output register: load and accept in the same cycle are allowed (back-to-back words). pix_data/
//   pix_idx/pix_last must stay stable while pix_valid=1 & pix_ready=0.
//  Frame timing with no back-pressure: load at cycle 0, samples at cycles 1..NPIX*HALF, and
//   exactly NPIX*HALF-1 shift pulses. First word has pix_valid=1 at cycle HALF+1.
//  Counters: bit_cnt 0..HALF-1, word_cnt 0..NPIX-1; neither wraps past its limit within a frame.
//  start during busy: ignored, no queueing. start in the frame_done cycle: accepted only if the
//   FSM is already in IDLE.
// TESTING
//  1 Reset: hold rst_n=0 for 3 cycles during SHIFT -> all outputs 0 next cycle, state IDLE,
//    no load/shift until the next start.
//  2 NPIX=2, ready=1, chain model loaded with 42'h2AA_AAAA_AAAA and 42'h155_5555_5555 -> words come
//    out in chain order with idx 0,1; pix_last only on idx 1; 41 shifts total; one frame_done.
//  3 Back-pressure: pix_ready=0 for 30 cycles while word 0 is valid -> at bit_cnt=20 of word 1,
//    shift=0 and data holds; release ready -> word 1 arrives intact, no bits lost.
//  4 Back-to-back: ready=1 -> pix_valid sets at cycle 22 and the next word appears exactly 21
//    cycles later.
//  5 start pulsed while busy, and again in the DRAIN cycle -> ignored; one frame of NPIX words.
//  6 Random pix_ready toggling (50%) over 100 frames checked against a scoreboard of loaded
//    pixels -> every word and pix_idx matches, one frame_done per frame.

Source files
------------

// File: rtl/sreg_readout_ctrl.sv
// Readout sequencer for the pixel shift-register chain: loads the chain, shifts it out
// over two serial lanes and rebuilds PIX_W-bit words onto a valid/ready stream.
module sreg_readout_ctrl #(
  parameter int NPIX  = 16,
  parameter int PIX_W = 42,
  localparam int HALF  = PIX_W / 2,
  localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1,
  localparam int BIT_W = (HALF > 1) ? $clog2(HALF) : 1
) (
  input  logic             sclk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       sreg_out,
  output logic             load,
  output logic             shift,
  output logic [PIX_W-1:0] pix_data,
  output logic [IDX_W-1:0] pix_idx,
  output logic             pix_last,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             busy,
  output logic             frame_done
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DRAIN} state_t;

  state_t           state_q, state_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0] word_cnt_q, word_cnt_d;
  logic [PIX_W-1:0] asm_q, asm_d;
  logic [PIX_W-1:0] pix_data_q, pix_data_d;
  logic [IDX_W-1:0] pix_idx_q, pix_idx_d;
  logic             pix_last_q, pix_last_d;
  logic             pix_valid_q, pix_valid_d;
  logic             frame_done_q, frame_done_d;

  logic last_bit, final_smp, can_take, accept;

  // A word-completing sample needs a free output register (empty or draining this cycle).
  assign last_bit  = (bit_cnt_q == BIT_W'(HALF - 1));
  assign final_smp = last_bit && (word_cnt_q == IDX_W'(NPIX - 1));
  assign can_take  = !last_bit || !pix_valid_q || pix_ready;
  assign accept    = pix_valid_q && pix_ready;

  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      asm_q        <= '0;
      pix_data_q   <= '0;
      pix_idx_q    <= '0;
      pix_last_q   <= 1'b0;
      pix_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      word_cnt_q   <= word_cnt_d;
      asm_q        <= asm_d;
      pix_data_q   <= pix_data_d;
      pix_idx_q    <= pix_idx_d;
      pix_last_q   <= pix_last_d;
      pix_valid_q  <= pix_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    word_cnt_d   = word_cnt_q;
    asm_d        = asm_q;
    pix_data_d   = pix_data_q;
    pix_idx_d    = pix_idx_q;
    pix_last_d   = pix_last_q;
    pix_valid_d  = pix_valid_q && !pix_ready;
    frame_done_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        bit_cnt_d  = '0;
        word_cnt_d = '0;
        state_d    = S_SHIFT;
      end
      S_SHIFT: begin
        if (can_take) begin
          for (int i = 0; i < HALF; i++) begin
            if (bit_cnt_q == BIT_W'(i)) begin
              asm_d[i]        = sreg_out[0];
              asm_d[HALF + i] = sreg_out[1];
            end
          end
          if (last_bit) begin
            pix_data_d  = asm_d;
            pix_idx_d   = word_cnt_q;
            pix_last_d  = (word_cnt_q == IDX_W'(NPIX - 1));
            pix_valid_d = 1'b1;
            bit_cnt_d   = '0;
            if (final_smp) state_d = S_DRAIN;
            else           word_cnt_d = word_cnt_q + IDX_W'(1);
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (accept) begin
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    load       = (state_q == S_LOAD);
    shift      = (state_q == S_SHIFT) && can_take && !final_smp;
    busy       = (state_q != S_IDLE);
    pix_data   = pix_data_q;
    pix_idx    = pix_idx_q;
    pix_last   = pix_last_q;
    pix_valid  = pix_valid_q;
    frame_done = frame_done_q;
  end

endmodule

// File: tb/tb_sreg_readout_ctrl.sv
// Bench for sreg_readout_ctrl: behavioural chain model plus a word scoreboard, driven by
// directed frames, back-pressure cases and randomized ready over many frames.
module tb_sreg_readout_ctrl;
  localparam int NPIX  = 2;
  localparam int PIX_W = 42;
  localparam int HALF  = PIX_W / 2;
  localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;

  logic             sclk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [1:0]       sreg_out;
  logic             load, shift;
  logic [PIX_W-1:0] pix_data;
  logic [IDX_W-1:0] pix_idx;
  logic             pix_last, pix_valid, pix_ready, busy, frame_done;

  sreg_readout_ctrl #(.NPIX(NPIX), .PIX_W(PIX_W)) dut (
    .sclk(sclk), .rst_n(rst_n), .start(start), .sreg_out(sreg_out),
    .load(load), .shift(shift), .pix_data(pix_data), .pix_idx(pix_idx),
    .pix_last(pix_last), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 sclk = ~sclk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Chain model: frame_pix is what the next load captures; lane0 carries the low half
  // of the current pixel LSB first, lane1 the high half, pixel 0 first.
  logic [PIX_W-1:0] frame_pix [NPIX];
  logic [PIX_W-1:0] chain_pix [NPIX];
  int               pos;

  function automatic logic [1:0] lanes(input logic [PIX_W-1:0] w, input int k);
    return {w[HALF + k], w[k]};
  endfunction

  always @(posedge sclk) begin
    if (load) begin
      chain_pix <= frame_pix;
      pos       <= 0;
      sreg_out  <= lanes(frame_pix[0], 0);
    end else if (shift) begin
      pos <= pos + 1;
      if (pos + 1 < NPIX * HALF) sreg_out <= lanes(chain_pix[(pos + 1) / HALF], (pos + 1) % HALF);
      else                       sreg_out <= 2'b00;
    end
  end

  // Scoreboard and monitor
  logic [PIX_W-1:0] exp_data_q [$];
  int               exp_idx_q  [$];
  int cyc = 0, load_cnt = 0, shift_cnt = 0, shift_all = 0, fd_cnt = 0, load_cyc = 0;
  int xfer_cyc [NPIX];
  bit               prev_hold = 0;
  logic [PIX_W-1:0] prev_data;
  logic [IDX_W-1:0] prev_idx;
  logic             prev_last;

  always @(posedge sclk) cyc <= cyc + 1;

  always @(negedge sclk) begin
    if (!rst_n) begin
      prev_hold = 0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", 64'(pix_valid), 64'(1));
        chk("hold_data", 64'(pix_data), 64'(prev_data));
        chk("hold_idx", 64'(pix_idx), 64'(prev_idx));
        chk("hold_last", 64'(pix_last), 64'(prev_last));
      end
      if (load) begin
        load_cnt++;
        load_cyc  = cyc;
        shift_cnt = 0;
      end
      if (shift) begin
        shift_cnt++;
        shift_all++;
      end
      if (frame_done) begin
        fd_cnt++;
        chk("shift_total", 64'(shift_cnt), 64'(NPIX * HALF - 1));
      end
      if (pix_valid && pix_ready) begin
        chk("sb_nonempty", 64'(exp_data_q.size() != 0), 64'(1));
        if (exp_data_q.size() != 0) begin
          automatic logic [PIX_W-1:0] ed = exp_data_q.pop_front();
          automatic int ei = exp_idx_q.pop_front();
          chk("word_data", 64'(pix_data), 64'(ed));
          chk("word_idx", 64'(pix_idx), 64'(ei));
          chk("word_last", 64'(pix_last), 64'(ei == NPIX - 1));
          $display("word idx=%0d data=%h last=%0d cyc=%0d", pix_idx, pix_data, pix_last, cyc);
        end
        xfer_cyc[pix_idx] = cyc;
      end
      prev_hold = pix_valid && !pix_ready;
      prev_data = pix_data;
      prev_idx  = pix_idx;
      prev_last = pix_last;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic push_frame();
    for (int i = 0; i < NPIX; i++) begin
      exp_data_q.push_back(frame_pix[i]);
      exp_idx_q.push_back(i);
    end
  endtask

  task automatic rand_frame();
    for (int i = 0; i < NPIX; i++) frame_pix[i] = {10'($urandom), 32'($urandom)};
  endtask

  task automatic pulse_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input bit rnd, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge sclk);
      if (frame_done) begin
        ok = 1;
        break;
      end
      tick();
      if (rnd) pix_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic wait_valid(input int idx, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge sclk);
      if (pix_valid && pix_idx == IDX_W'(idx)) begin
        ok = 1;
        break;
      end
      tick();
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_load"}, 64'(load), 64'(0));
    chk({tag, "_shift"}, 64'(shift), 64'(0));
    chk({tag, "_valid"}, 64'(pix_valid), 64'(0));
    chk({tag, "_data"}, 64'(pix_data), 64'(0));
    chk({tag, "_idx"}, 64'(pix_idx), 64'(0));
    chk({tag, "_last"}, 64'(pix_last), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_fdone"}, 64'(frame_done), 64'(0));
  endtask

  initial begin
    bit ok;
    int lc0, fd0, sa0;
    rst_n = 1'b0; start = 1'b0; pix_ready = 1'b0; sreg_out = 2'b00;
    for (int i = 0; i < NPIX; i++) frame_pix[i] = '0;

    // Power-on reset
    repeat (3) tick();
    @(negedge sclk);
    chk_outputs_zero("por");
    tick();
    rst_n = 1'b1;

    // Directed frame, ready high: order, idx, last, timing, one frame_done
    frame_pix[0] = 42'h2AA_AAAA_AAAA;
    frame_pix[1] = 42'h155_5555_5555;
    pix_ready = 1'b1;
    fd0 = fd_cnt;
    push_frame();
    pulse_start();
    wait_done(0, 200, ok);
    chk("t2_done", 64'(ok), 64'(1));
    tick();
    @(negedge sclk);
    chk("t2_fd_pulse", 64'(frame_done), 64'(0));
    chk("t2_fd_cnt", 64'(fd_cnt - fd0), 64'(1));
    chk("t2_busy", 64'(busy), 64'(0));
    chk("t4_first", 64'(xfer_cyc[0] - load_cyc), 64'(HALF + 1));
    chk("t4_next", 64'(xfer_cyc[1] - xfer_cyc[0]), 64'(HALF));
    $display("directed frame: first word at +%0d, next after %0d", xfer_cyc[0] - load_cyc,
             xfer_cyc[1] - xfer_cyc[0]);

    // Reset mid-frame with a word pending: everything discarded, no activity afterwards
    rand_frame();
    pix_ready = 1'b0;
    push_frame();
    pulse_start();
    wait_valid(0, 100, ok);
    chk("t1_valid", 64'(ok), 64'(1));
    repeat (5) tick();
    rst_n = 1'b0;
    repeat (3) tick();
    @(negedge sclk);
    chk_outputs_zero("t1_rst");
    exp_data_q.delete();
    exp_idx_q.delete();
    lc0 = load_cnt;
    sa0 = shift_all;
    tick();
    rst_n = 1'b1;
    pix_ready = 1'b1;
    repeat (20) tick();
    @(negedge sclk);
    chk("t1_no_load", 64'(load_cnt - lc0), 64'(0));
    chk("t1_no_shift", 64'(shift_all - sa0), 64'(0));
    chk("t1_idle", 64'(busy), 64'(0));

    // Back-pressure: word 0 held 30 cycles, chain stalls at the last bit of word 1
    rand_frame();
    pix_ready = 1'b0;
    fd0 = fd_cnt;
    push_frame();
    pulse_start();
    wait_valid(0, 100, ok);
    chk("t3_valid", 64'(ok), 64'(1));
    repeat (30) tick();
    @(negedge sclk);
    chk("t3_stall_shift", 64'(shift), 64'(0));
    chk("t3_stall_valid", 64'(pix_valid), 64'(1));
    chk("t3_stall_idx", 64'(pix_idx), 64'(0));
    chk("t3_stall_shifts", 64'(shift_cnt), 64'(HALF + HALF - 1));
    chk("t3_busy", 64'(busy), 64'(1));
    tick();
    pix_ready = 1'b1;
    wait_done(0, 200, ok);
    chk("t3_done", 64'(ok), 64'(1));
    tick();
    @(negedge sclk);
    chk("t3_fd_cnt", 64'(fd_cnt - fd0), 64'(1));

    // start while busy and during DRAIN is ignored
    rand_frame();
    pix_ready = 1'b1;
    lc0 = load_cnt;
    fd0 = fd_cnt;
    push_frame();
    pulse_start();
    repeat (5) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(0, 100, ok);
    chk("t5_w0", 64'(ok), 64'(1));
    tick();
    pix_ready = 1'b0;
    wait_valid(1, 100, ok);
    chk("t5_w1", 64'(ok), 64'(1));
    chk("t5_drain_busy", 64'(busy), 64'(1));
    chk("t5_drain_last", 64'(pix_last), 64'(1));
    start = 1'b1;
    tick();
    start = 1'b0;
    pix_ready = 1'b1;
    wait_done(0, 100, ok);
    chk("t5_done", 64'(ok), 64'(1));
    repeat (30) tick();
    @(negedge sclk);
    chk("t5_loads", 64'(load_cnt - lc0), 64'(1));
    chk("t5_fd_cnt", 64'(fd_cnt - fd0), 64'(1));
    chk("t5_idle", 64'(busy), 64'(0));
    chk("t5_sb_empty", 64'(exp_data_q.size()), 64'(0));

    // Random ready over 100 frames; each new start lands in the previous frame_done cycle
    lc0 = load_cnt;
    fd0 = fd_cnt;
    tick();
    for (int f = 0; f < 100; f++) begin
      rand_frame();
      push_frame();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(1, 3000, ok);
      chk("t6_done", 64'(ok), 64'(1));
      if (!ok) break;
    end
    pix_ready = 1'b1;
    tick();
    @(negedge sclk);
    chk("t6_loads", 64'(load_cnt - lc0), 64'(100));
    chk("t6_fd_cnt", 64'(fd_cnt - fd0), 64'(100));
    chk("t6_sb_empty", 64'(exp_data_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
